top: RTL and testbench
======================

Name: top

Overview:
- Dual-channel combinational-function block with registered outputs. Each channel is a 4:1 mux, 1:4 demux, 2:4 decoder or 4:2 priority encoder, chosen by its own mode input.
- Channel 1 is controlled by mode1 and channel 2 by mode2.
- Data and select inputs are shared between channels, except the decoder inputs, which are per channel.
- Sits as the top-level wrapper over the four primitive functions.

Parameters:
None (all widths fixed).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (sampled on rising clk edge)
mode1  input  2  channel 1 function: 00 mux, 01 demux, 10 decoder, 11 encoder
mode2  input  2  channel 2 function, same encoding
inmux  input  4  mux data input (both channels)
inenc1  input  4  encoder data input (both channels)
indemux  input  1  demux data bit (both channels)
indec1  input  2  channel 1 decoder input
indec2  input  2  channel 2 decoder input
seldemux  input  2  demux select (both channels)
selmux  input  2  mux select (both channels)
outmux1  output  1  channel 1 mux result
outmux2  output  1  channel 2 mux result
outdemux  output  4  channel 1 demux result
outdec1  output  4  channel 1 decoder result
outdemux2  output  4  channel 2 demux result
outdec2  output  4  channel 2 decoder result
outenc1  output  2  channel 1 encoder result
outenc2  output  2  channel 2 encoder result

Behaviour:
- All outputs are registered and update only on the rising edge of clk. Latency is 1 cycle: inputs sampled at edge N appear after edge N.
- Reset: if reset==0 at a rising edge, every output becomes 0 (outmux1/2=0; outdemux, outdemux2, outdec1, outdec2=4'b0000; outenc1/2=2'b00). Reset has priority over all function updates. Reset mid-operation clears outputs on that edge; normal operation resumes on the first edge with reset==1.
- Per channel, per edge with reset==1:
  - Only the output group of the selected function is loaded with the new result.
  - All other output groups of that channel are loaded with 0.
- Mux (mode 00): outmuxN = inmux[selmux].
- Demux (mode 01): outdemuxN[seldemux] = indemux; the other three bits are 0.
- Decoder (mode 10): outdecN = 4'b0001 << indecN (one-hot).
- Encoder (mode 11): 4:2 priority encoder on inenc1; the highest set bit index wins. 1xxx->11, 01xx->10, 001x->01, 0001->00. Input 0000 -> 00 (no valid flag).
- Channels are fully independent. Both may select the same function simultaneously; each computes from the shared inputs (its own indecN for the decoder).
- X/undriven inputs are not required to be handled; the bench drives all inputs before releasing reset.

Test Plan:
- Reset: hold reset=0 for 2 cycles with arbitrary inputs -> all outputs 0. Then release with mode1=mode2=00, inmux=4'b1001, selmux=01 -> after next edge outmux1=outmux2=0. With selmux=11 -> outmux1=outmux2=1.
- Demux: mode1=01, indemux=1, seldemux=10 -> outdemux=4'b0100 one cycle later. Other channel-1 outputs are 0 (outmux1=0, outdec1=0000, outenc1=00).
- Decoder per channel: mode1=mode2=10, indec1=11, indec2=01 -> outdec1=4'b1000, outdec2=4'b0010.
- Encoder priority: mode2=11 with inenc1 sequence 0000, 0001, 0110, 1010 -> outenc2 = 00, 00, 10, 11 on successive cycles.
- Mode switch and independence: mode1=00, mode2=01, inmux=4'b0100, selmux=10, indemux=1, seldemux=00 -> outmux1=1, outdemux2=4'b0001. Next cycle swap modes (mode1=01, mode2=00), inputs unchanged -> outmux1=0, outdemux=0001, outmux2=1, outdemux2=0000.
- Reset mid-operation: while mode1=10 with outdec1=0100, drive reset=0 for one edge -> all outputs 0. On release with inputs unchanged -> outdec1=0100 after next edge.

Source files
------------

// File: rtl/top.sv
// Dual-channel function block: each channel runs a 4:1 mux, 1:4 demux, 2:4 decoder
// or 4:2 priority encoder, picked by its own mode. All outputs are registered with
// one cycle of latency. Only the selected function's output group is loaded; the
// channel's other groups are cleared on the same edge.
module top (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode1,
    input  logic [1:0] mode2,
    input  logic [3:0] inmux,
    input  logic [3:0] inenc1,
    input  logic       indemux,
    input  logic [1:0] indec1,
    input  logic [1:0] indec2,
    input  logic [1:0] seldemux,
    input  logic [1:0] selmux,
    output logic       outmux1,
    output logic       outmux2,
    output logic [3:0] outdemux,
    output logic [3:0] outdec1,
    output logic [3:0] outdemux2,
    output logic [3:0] outdec2,
    output logic [1:0] outenc1,
    output logic [1:0] outenc2
);

    typedef enum logic [1:0] {
        ModeMux    = 2'b00,
        ModeDemux  = 2'b01,
        ModeDecode = 2'b10,
        ModeEncode = 2'b11
    } mode_e;

    // Shared primitive results
    logic       mux_bit;
    logic [3:0] demux_vec;
    logic [3:0] dec1_vec;
    logic [3:0] dec2_vec;
    logic [1:0] enc_val;

    // Per-channel next-state values
    logic       mux1_d, mux2_d;
    logic [3:0] demux1_d, demux2_d;
    logic [3:0] dec1_d, dec2_d;
    logic [1:0] enc1_d, enc2_d;

    // Registered state
    logic       mux1_q, mux2_q;
    logic [3:0] demux1_q, demux2_q;
    logic [3:0] dec1_q, dec2_q;
    logic [1:0] enc1_q, enc2_q;

    // Evaluate the four primitive functions from the shared/per-channel inputs
    always_comb begin
        mux_bit            = inmux[selmux];
        demux_vec          = 4'b0000;
        demux_vec[seldemux] = indemux;
        dec1_vec           = 4'b0001 << indec1;
        dec2_vec           = 4'b0001 << indec2;
        // Highest set bit wins; all-zero input encodes as 00
        casez (inenc1)
            4'b1???: enc_val = 2'b11;
            4'b01??: enc_val = 2'b10;
            4'b001?: enc_val = 2'b01;
            default: enc_val = 2'b00;
        endcase
    end

    // Channel 1 output-group steering: unselected groups load zero
    always_comb begin
        mux1_d   = 1'b0;
        demux1_d = 4'b0000;
        dec1_d   = 4'b0000;
        enc1_d   = 2'b00;
        unique case (mode_e'(mode1))
            ModeMux:    mux1_d   = mux_bit;
            ModeDemux:  demux1_d = demux_vec;
            ModeDecode: dec1_d   = dec1_vec;
            ModeEncode: enc1_d   = enc_val;
            default:    ;
        endcase
    end

    // Channel 2 output-group steering: unselected groups load zero
    always_comb begin
        mux2_d   = 1'b0;
        demux2_d = 4'b0000;
        dec2_d   = 4'b0000;
        enc2_d   = 2'b00;
        unique case (mode_e'(mode2))
            ModeMux:    mux2_d   = mux_bit;
            ModeDemux:  demux2_d = demux_vec;
            ModeDecode: dec2_d   = dec2_vec;
            ModeEncode: enc2_d   = enc_val;
            default:    ;
        endcase
    end

    // Output registers with synchronous active-low clear taking priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            mux1_q   <= 1'b0;
            mux2_q   <= 1'b0;
            demux1_q <= 4'b0000;
            demux2_q <= 4'b0000;
            dec1_q   <= 4'b0000;
            dec2_q   <= 4'b0000;
            enc1_q   <= 2'b00;
            enc2_q   <= 2'b00;
        end else begin
            mux1_q   <= mux1_d;
            mux2_q   <= mux2_d;
            demux1_q <= demux1_d;
            demux2_q <= demux2_d;
            dec1_q   <= dec1_d;
            dec2_q   <= dec2_d;
            enc1_q   <= enc1_d;
            enc2_q   <= enc2_d;
        end
    end

    assign outmux1   = mux1_q;
    assign outmux2   = mux2_q;
    assign outdemux  = demux1_q;
    assign outdemux2 = demux2_q;
    assign outdec1   = dec1_q;
    assign outdec2   = dec2_q;
    assign outenc1   = enc1_q;
    assign outenc2   = enc2_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the per-channel functions.
module tb_top;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode1, mode2;
    logic [3:0] inmux, inenc1;
    logic       indemux;
    logic [1:0] indec1, indec2, seldemux, selmux;
    logic       outmux1, outmux2;
    logic [3:0] outdemux, outdec1, outdemux2, outdec2;
    logic [1:0] outenc1, outenc2;

    int checks = 0;
    int errors = 0;

    logic [21:0] dut_vec;
    logic [21:0] exp_vec;

    assign dut_vec = {outmux1, outmux2, outdemux, outdec1, outdemux2, outdec2, outenc1, outenc2};

    top dut (
        .clk      (clk),
        .reset    (reset),
        .mode1    (mode1),
        .mode2    (mode2),
        .inmux    (inmux),
        .inenc1   (inenc1),
        .indemux  (indemux),
        .indec1   (indec1),
        .indec2   (indec2),
        .seldemux (seldemux),
        .selmux   (selmux),
        .outmux1  (outmux1),
        .outmux2  (outmux2),
        .outdemux (outdemux),
        .outdec1  (outdec1),
        .outdemux2(outdemux2),
        .outdec2  (outdec2),
        .outenc1  (outenc1),
        .outenc2  (outenc2)
    );

    always #5 clk = ~clk;

    // One channel's result as {mux, demux[3:0], dec[3:0], enc[1:0]}
    function automatic logic [10:0] chan(input logic [1:0] mode, input logic [1:0] dec_in);
        int          m, dm, dc, en;
        logic [10:0] r;
        m = 0; dm = 0; dc = 0; en = 0;
        if (mode == 2'd0) m = (int'(inmux) >> int'(selmux)) % 2;
        if (mode == 2'd1) dm = indemux ? (1 << int'(seldemux)) : 0;
        if (mode == 2'd2) dc = 1 << int'(dec_in);
        if (mode == 2'd3)
            for (int i = 0; i < 4; i++) if (((int'(inenc1) >> i) % 2) == 1) en = i;
        r = {m[0], dm[3:0], dc[3:0], en[1:0]};
        return r;
    endfunction

    // Expected outputs after the coming edge, from the inputs currently applied
    function automatic logic [21:0] model();
        logic [10:0] c1, c2;
        if (reset == 1'b0) return 22'd0;
        c1 = chan(mode1, indec1);
        c2 = chan(mode2, indec2);
        return {c1[10], c2[10], c1[9:6], c1[5:2], c2[9:6], c2[5:2], c1[1:0], c2[1:0]};
    endfunction

    // Capture expectation, advance one edge, settle
    task automatic tick();
        exp_vec = model();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        mode1    = 2'($urandom);
        mode2    = 2'($urandom);
        inmux    = 4'($urandom);
        inenc1   = 4'($urandom);
        indemux  = 1'($urandom);
        indec1   = 2'($urandom);
        indec2   = 2'($urandom);
        seldemux = 2'($urandom);
        selmux   = 2'($urandom);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        randomize_inputs();
        tick();
        randomize_inputs();
        tick();
        checks++;
        if (dut_vec !== 22'd0) begin
            errors++;
            $display("FAIL reset_clear: got %h expected %h", dut_vec, 22'd0);
        end
        reset = 1'b1;
        mode1 = 2'b00; mode2 = 2'b00; inmux = 4'b1001; selmux = 2'b01;
        tick();
        checks++;
        if ({outmux1, outmux2} !== 2'b00) begin
            errors++;
            $display("FAIL mux_sel01: got %b expected 00", {outmux1, outmux2});
        end
        selmux = 2'b11;
        tick();
        checks++;
        if ({outmux1, outmux2} !== 2'b11) begin
            errors++;
            $display("FAIL mux_sel11: got %b expected 11", {outmux1, outmux2});
        end
        checks++;
        if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL mux_full: got %h expected %h", dut_vec, exp_vec);
        end
    endtask

    task automatic test_demux();
        mode1 = 2'b01; indemux = 1'b1; seldemux = 2'b10;
        tick();
        checks++;
        if (outdemux !== 4'b0100) begin
            errors++;
            $display("FAIL demux_out: got %b expected 0100", outdemux);
        end
        checks++;
        if ({outmux1, outdec1, outenc1} !== 7'd0) begin
            errors++;
            $display("FAIL demux_others: got %b expected 0", {outmux1, outdec1, outenc1});
        end
    endtask

    task automatic test_decoder();
        mode1 = 2'b10; mode2 = 2'b10; indec1 = 2'b11; indec2 = 2'b01;
        tick();
        checks++;
        if (outdec1 !== 4'b1000 || outdec2 !== 4'b0010) begin
            errors++;
            $display("FAIL decoder: got %b/%b expected 1000/0010", outdec1, outdec2);
        end
    endtask

    task automatic test_encoder();
        logic [3:0] pat [4];
        logic [1:0] want [4];
        pat[0] = 4'b0000; pat[1] = 4'b0001; pat[2] = 4'b0110; pat[3] = 4'b1010;
        want[0] = 2'b00; want[1] = 2'b00; want[2] = 2'b10; want[3] = 2'b11;
        mode2 = 2'b11;
        for (int i = 0; i < 4; i++) begin
            inenc1 = pat[i];
            tick();
            checks++;
            if (outenc2 !== want[i]) begin
                errors++;
                $display("FAIL encoder_%0d: got %b expected %b", i, outenc2, want[i]);
            end
        end
    endtask

    task automatic test_mode_switch();
        mode1 = 2'b00; mode2 = 2'b01; inmux = 4'b0100; selmux = 2'b10;
        indemux = 1'b1; seldemux = 2'b00;
        tick();
        checks++;
        if (outmux1 !== 1'b1 || outdemux2 !== 4'b0001) begin
            errors++;
            $display("FAIL switch_a: got %b/%b expected 1/0001", outmux1, outdemux2);
        end
        mode1 = 2'b01; mode2 = 2'b00;
        tick();
        checks++;
        if ({outmux1, outdemux, outmux2, outdemux2} !== {1'b0, 4'b0001, 1'b1, 4'b0000}) begin
            errors++;
            $display("FAIL switch_b: got %b expected 0_0001_1_0000",
                     {outmux1, outdemux, outmux2, outdemux2});
        end
    endtask

    task automatic test_reset_mid();
        mode1 = 2'b10; indec1 = 2'b10;
        tick();
        checks++;
        if (outdec1 !== 4'b0100) begin
            errors++;
            $display("FAIL mid_pre: got %b expected 0100", outdec1);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (dut_vec !== 22'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h expected 0", dut_vec);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outdec1 !== 4'b0100) begin
            errors++;
            $display("FAIL mid_resume: got %b expected 0100", outdec1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            reset = ($urandom_range(0, 9) != 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_demux();
        test_decoder();
        test_encoder();
        test_mode_switch();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
